// File: rtl/count_event_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : count_mon_pkg
// Description : Shared definitions for the counter event monitor. The event
//               record is {load_f, wrap_f, match_f, dir_f, count}; the flag
//               positions sit directly above the count field, so they are
//               expressed as functions of the count width.
// Revision    : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

  // Number of flag bits stacked on top of the count field.
  localparam int EVT_FLAG_BITS = 4;

  // Total record width for a given count width.
  function automatic int evt_width(input int cnt_width);
    return cnt_width + EVT_FLAG_BITS;
  endfunction

  // Flag bit positions inside the record (LOAD / WRAP / MATCH / DIR).
  function automatic int load_bit(input int cnt_width);
    return cnt_width + 3;
  endfunction

  function automatic int wrap_bit(input int cnt_width);
    return cnt_width + 2;
  endfunction

  function automatic int match_bit(input int cnt_width);
    return cnt_width + 1;
  endfunction

  function automatic int dir_bit(input int cnt_width);
    return cnt_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_event_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_fifo
// Description : Single-clock FIFO for event records. A push into a full FIFO
//               is accepted only when a pop happens on the same edge; pops
//               on an empty FIFO are ignored. The head is presented
//               combinationally and reads as zero while empty.
// Ports       : clk, reset_n (async, active-low)
//               i_push / i_wr_data   - write request and record
//               i_pop                - remove head (ignored when empty)
//               o_rd_data            - head record
//               o_full / o_empty     - occupancy flags
//               o_level              - occupancy, one bit wider than pointers
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4          // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int                 c_ptr_w    = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full_lvl = DEPTH[c_ptr_w:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_level;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == c_full_lvl);
  assign o_level = r_level;

  // A pop frees a slot on the same edge, so a full FIFO can still take a push.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;   // wraps naturally at DEPTH
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_event_monitor
// Description : Watches an up/down counter and queues one record per cycle
//               for load, wrap-around and compare-match events. The counter
//               updates on the same edge that samples load_in/dir_in, so the
//               value seen in cycle t is judged against the history captured
//               at the end of cycle t-1.
// Ports       : clk, reset_n (async, active-low)
//               mon_en            - enable event detection
//               cnt_in            - counter value
//               load_in, dir_in   - counter controls (dir 1 = up)
//               cmp_val           - match compare value
//               evt_valid/ready   - head handshake, evt_data = head record
//               fifo_level        - occupancy
//               ovf / clr_ovf     - sticky drop flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_WIDTH  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              mon_en,
  input  logic [CNT_WIDTH-1:0]              cnt_in,
  input  logic                              load_in,
  input  logic                              dir_in,
  input  logic [CNT_WIDTH-1:0]              cmp_val,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [evt_width(CNT_WIDTH)-1:0]   evt_data,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              ovf,
  input  logic                              clr_ovf
);

  localparam int                   c_evt_w     = evt_width(CNT_WIDTH);
  localparam int                   c_load_bit  = load_bit(CNT_WIDTH);
  localparam int                   c_wrap_bit  = wrap_bit(CNT_WIDTH);
  localparam int                   c_match_bit = match_bit(CNT_WIDTH);
  localparam int                   c_dir_bit   = dir_bit(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;

  // History of the previous cycle.
  logic [CNT_WIDTH-1:0] r_prev_cnt;
  logic                 r_prev_load;
  logic                 r_prev_dir;
  logic                 r_hist_valid;
  logic                 r_ovf;

  logic               w_load_f;
  logic               w_wrap_f;
  logic               w_match_f;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [c_evt_w-1:0] w_evt_rec;

  // History runs regardless of mon_en so re-enabling never sees stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_cnt   <= '0;
      r_prev_load  <= 1'b0;
      r_prev_dir   <= 1'b0;
      r_hist_valid <= 1'b0;
    end else begin
      r_prev_cnt   <= cnt_in;
      r_prev_load  <= load_in;
      r_prev_dir   <= dir_in;
      r_hist_valid <= 1'b1;
    end
  end

  // A loaded value is never a wrap, even when it lands on 0 or MAX.
  assign w_load_f  = r_prev_load;
  assign w_wrap_f  = !r_prev_load &&
                     (( r_prev_dir && (r_prev_cnt == c_cnt_max) && (cnt_in == '0)) ||
                      (!r_prev_dir && (r_prev_cnt == '0)        && (cnt_in == c_cnt_max)));
  // Match only on arrival at cmp_val, not while the counter parks there.
  assign w_match_f = (cnt_in == cmp_val) && ((cnt_in != r_prev_cnt) || r_prev_load);

  assign w_push = r_hist_valid && mon_en && (w_load_f || w_wrap_f || w_match_f);

  always_comb begin
    w_evt_rec               = '0;
    w_evt_rec[CNT_WIDTH-1:0] = cnt_in;
    w_evt_rec[c_dir_bit]    = r_prev_dir;
    w_evt_rec[c_match_bit]  = w_match_f;
    w_evt_rec[c_wrap_bit]   = w_wrap_f;
    w_evt_rec[c_load_bit]   = w_load_f;
  end

  assign w_pop     = evt_ready && !w_empty;
  assign evt_valid = !w_empty;

  evt_sync_fifo #(
    .WIDTH (c_evt_w),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_wr_data (w_evt_rec),
    .i_pop     (w_pop),
    .o_rd_data (evt_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;

endmodule
`default_nettype wire
